// File: rtl/uart_tx.sv
// UART transmitter: one byte per valid/ready handshake, framed as start, 8 data bits LSB first,
// optional parity and 1 or 2 stop bits. The line and the handshake outputs are all registered.
module uart_tx #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 12_000_000,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [7:0] data_byte_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       uart_txd_out,
    output logic       done_out
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic             STOP_END = 1'(STOP_BITS - 1);
    localparam logic             PAR_ODD  = (PARITY == 1);

    if (CLKS_PER_BIT < 2) begin : g_cpb_check
        $error("uart_tx: CLK_FREQ / BAUD_RATE must be at least 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_stop_check
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_parity_check
        $error("uart_tx: PARITY must be 0, 1 or 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic             stop_cnt;
    logic [7:0]       shreg;
    logic             par_bit;
    logic             accept;
    logic             bit_end;
    logic             stop_last;

    assign accept    = valid_in && ready_out;
    assign bit_end   = (baud_cnt == CNT_LAST);
    assign stop_last = (stop_cnt == STOP_END);

    // Payload registers carry no reset: they are always reloaded at acceptance.
    always_ff @(posedge clk_in) begin
        if (state == S_IDLE && accept) begin
            shreg   <= data_byte_in;
            par_bit <= (^data_byte_in) ^ PAR_ODD;
        end else if (state == S_DATA && bit_end) begin
            shreg <= shreg >> 1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state        <= S_IDLE;
            baud_cnt     <= '0;
            bit_idx      <= '0;
            stop_cnt     <= 1'b0;
            uart_txd_out <= 1'b1;
            ready_out    <= 1'b1;
            done_out     <= 1'b0;
        end else begin
            // Raised one cycle early so the registered pulse lands on the last stop cycle.
            done_out <= (state == S_STOP) && stop_last && (baud_cnt == CNT_PRE);
            if (state != S_IDLE) begin
                baud_cnt <= bit_end ? '0 : baud_cnt + CNT_W'(1);
            end
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state        <= S_START;
                        baud_cnt     <= '0;
                        uart_txd_out <= 1'b0;
                        ready_out    <= 1'b0;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        state        <= S_DATA;
                        bit_idx      <= '0;
                        uart_txd_out <= shreg[0];
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        if (bit_idx == 3'd7) begin
                            if (PARITY != 0) begin
                                state        <= S_PARITY;
                                uart_txd_out <= par_bit;
                            end else begin
                                state        <= S_STOP;
                                stop_cnt     <= 1'b0;
                                uart_txd_out <= 1'b1;
                            end
                        end else begin
                            bit_idx      <= bit_idx + 3'd1;
                            uart_txd_out <= shreg[1];
                        end
                    end
                end
                S_PARITY: begin
                    if (bit_end) begin
                        state        <= S_STOP;
                        stop_cnt     <= 1'b0;
                        uart_txd_out <= 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        if (stop_last) begin
                            state     <= S_IDLE;
                            ready_out <= 1'b1;
                        end else begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state        <= S_IDLE;
                    uart_txd_out <= 1'b1;
                    ready_out    <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four parameterisations side by side, line traces recorded per cycle
// and compared against hand-written frame bit patterns.
module tb_uart_tx;
    localparam int CPB = 8;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] valid;
    logic [7:0] data [4];
    logic [3:0] txd;
    logic [3:0] rdy;
    logic [3:0] dn;

    logic lv [0:299];
    logic rv [0:299];
    logic dv [0:299];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_tx dut_plain (
        .clk_in(clk), .rst_in(rst_n), .data_byte_in(data[0]), .valid_in(valid[0]),
        .ready_out(rdy[0]), .uart_txd_out(txd[0]), .done_out(dn[0])
    );
    uart_tx #(.PARITY(2)) dut_even (
        .clk_in(clk), .rst_in(rst_n), .data_byte_in(data[1]), .valid_in(valid[1]),
        .ready_out(rdy[1]), .uart_txd_out(txd[1]), .done_out(dn[1])
    );
    uart_tx #(.PARITY(1)) dut_odd (
        .clk_in(clk), .rst_in(rst_n), .data_byte_in(data[2]), .valid_in(valid[2]),
        .ready_out(rdy[2]), .uart_txd_out(txd[2]), .done_out(dn[2])
    );
    uart_tx #(.STOP_BITS(2)) dut_stop2 (
        .clk_in(clk), .rst_in(rst_n), .data_byte_in(data[3]), .valid_in(valid[3]),
        .ready_out(rdy[3]), .uart_txd_out(txd[3]), .done_out(dn[3])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Acceptance happens on the posedge inside this task; cycle 1 of the frame follows it.
    task automatic accept(input int i, input logic [7:0] b, input bit hold);
        @(negedge clk);
        check("ready_before_accept", 32'(rdy[i]), 32'd1);
        data[i]  = b;
        valid[i] = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) begin
            valid[i] = 1'b0;
            data[i]  = ~b;
        end
    endtask

    task automatic capture(input int i, input int from, input int to);
        for (int k = from; k <= to; k++) begin
            @(negedge clk);
            lv[k] = txd[i];
            rv[k] = rdy[i];
            dv[k] = dn[i];
        end
    endtask

    // bits holds the line levels of one frame, first bit in the LSB, one entry per bit period.
    task automatic check_frame(input string tag, input int base, input logic [11:0] bits, input int nb);
        int len;
        len = nb * CPB;
        for (int k = 1; k <= len; k++) begin
            check({tag, "_line"},  32'(lv[base + k]), 32'(bits[(k - 1) / CPB]));
            check({tag, "_ready"}, 32'(rv[base + k]), 32'd0);
            check({tag, "_done"},  32'(dv[base + k]), 32'(k == len));
        end
        check({tag, "_idle_line"},  32'(lv[base + len + 1]), 32'd1);
        check({tag, "_idle_ready"}, 32'(rv[base + len + 1]), 32'd1);
        check({tag, "_idle_done"},  32'(dv[base + len + 1]), 32'd0);
    endtask

    // Receiver model: samples each data bit in the middle of its period.
    function automatic logic [7:0] rx_byte(input int base);
        logic [7:0] r;
        for (int n = 0; n < 8; n++) r[n] = lv[base + CPB * (n + 1) + CPB / 2];
        return r;
    endfunction

    task automatic reset_mid_frame(input int bit_no, input logic pre_level);
        int at;
        at = CPB * (1 + bit_no) + CPB / 2;
        accept(0, 8'h96, 1'b0);
        capture(0, 1, at);
        check("rst_pre_line", 32'(lv[at]), 32'(pre_level));
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_line",  32'(txd[0]), 32'd1);
        check("rst_async_ready", 32'(rdy[0]), 32'd1);
        check("rst_async_done",  32'(dn[0]),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        capture(0, 1, 100);
        for (int k = 1; k <= 100; k++) begin
            check("rst_after_line",  32'(lv[k]), 32'd1);
            check("rst_after_ready", 32'(rv[k]), 32'd1);
            check("rst_after_done",  32'(dv[k]), 32'd0);
        end
    endtask

    initial begin
        valid = '0;
        for (int i = 0; i < 4; i++) data[i] = 8'h00;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check("reset_line",  32'(txd[i]), 32'd1);
            check("reset_ready", 32'(rdy[i]), 32'd1);
            check("reset_done",  32'(dn[i]),  32'd0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        accept(0, 8'hA5, 1'b0);
        capture(0, 1, 81);
        check_frame("a5_plain", 0, 12'b00_1_10100101_0, 10);

        accept(1, 8'hA5, 1'b0);
        capture(1, 1, 89);
        check_frame("a5_even", 0, 12'b0_1_0_10100101_0, 11);

        accept(2, 8'hA5, 1'b0);
        capture(2, 1, 89);
        check_frame("a5_odd", 0, 12'b0_1_1_10100101_0, 11);

        accept(1, 8'h07, 1'b0);
        capture(1, 1, 89);
        check_frame("07_even", 0, 12'b0_1_1_00000111_0, 11);

        accept(3, 8'hFF, 1'b0);
        capture(3, 1, 89);
        check_frame("ff_stop2", 0, 12'b0_1_1_11111111_0, 11);

        // Back-to-back with valid held: second frame starts after a single idle cycle.
        accept(0, 8'h00, 1'b1);
        data[0] = 8'h55;
        capture(0, 1, 162);
        valid[0] = 1'b0;
        check_frame("b2b_first",  0,  12'b00_1_00000000_0, 10);
        check_frame("b2b_second", 81, 12'b00_1_01010101_0, 10);
        check("b2b_rx_first",  32'(rx_byte(0)),  32'h00);
        check("b2b_rx_second", 32'(rx_byte(81)), 32'h55);

        // A request raised mid-frame waits for ready and does not disturb the frame in flight.
        accept(0, 8'h81, 1'b0);
        capture(0, 1, 20);
        valid[0] = 1'b1;
        data[0]  = 8'h3C;
        capture(0, 21, 82);
        valid[0] = 1'b0;
        data[0]  = 8'hFF;
        capture(0, 83, 162);
        check_frame("mid_first",  0,  12'b00_1_10000001_0, 10);
        check_frame("mid_second", 81, 12'b00_1_00111100_0, 10);
        check("mid_rx_second", 32'(rx_byte(81)), 32'h3C);

        reset_mid_frame(4, 1'b1);
        reset_mid_frame(3, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
